// File: rtl/enemy_bullet_ctl_pkg.sv
// enemy_bullet_ctl_pkg: shared game coordinate width and screen height
package enemy_bullet_ctl_pkg;
  localparam int COORD_W = 12;
  localparam int SCREEN_H = 600;
endpackage

// File: rtl/enemy_bullet_ctl.sv
// enemy_bullet_ctl: single enemy bullet spawn, fall, retire and cooldown control
module enemy_bullet_ctl
  import enemy_bullet_ctl_pkg::*;
#(
  parameter int SPEED = 4,
  parameter int Y_MAX = SCREEN_H,
  parameter int X_OFFSET = 16,
  parameter int Y_OFFSET = 32,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               on,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] enemy_xpos,
  input  logic [COORD_W-1:0] enemy_ypos,
  input  logic               hit,
  output logic [COORD_W-1:0] bullet_xpos,
  output logic [COORD_W-1:0] bullet_ypos,
  output logic               bullet_active,
  output logic               fired
);
  typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;
  localparam logic [COORD_W-1:0] XO = COORD_W'(X_OFFSET);
  localparam logic [COORD_W-1:0] YO = COORD_W'(Y_OFFSET);
  localparam logic [COORD_W:0] SPD = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0] YMX = (COORD_W+1)'(Y_MAX);
  localparam logic [7:0] CDF = 8'(COOLDOWN_FRAMES);
  state_t state, state_n;
  logic [COORD_W-1:0] x_n, y_n;
  logic [COORD_W:0] y_sum;
  logic active_n, fired_n;
  logic [7:0] cnt, cnt_n;
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      bullet_xpos <= '0;
      bullet_ypos <= '0;
      bullet_active <= 1'b0;
      fired <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      bullet_xpos <= x_n;
      bullet_ypos <= y_n;
      bullet_active <= active_n;
      fired <= fired_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    x_n = bullet_xpos;
    y_n = bullet_ypos;
    active_n = bullet_active;
    fired_n = 1'b0;
    cnt_n = cnt;
    y_sum = {1'b0, bullet_ypos} + SPD;
    case (state)
      IDLE: if (on) begin
        state_n = FLY;
        x_n = enemy_xpos + XO;
        y_n = enemy_ypos + YO;
        active_n = 1'b1;
        fired_n = 1'b1;
      end
      FLY: if (hit || (frame_tick && y_sum >= YMX)) begin
        state_n = COOLDOWN;
        active_n = 1'b0;
        cnt_n = '0;
      end else if (frame_tick) y_n = y_sum[COORD_W-1:0];
      COOLDOWN: if (cnt == CDF) state_n = IDLE;
      else if (frame_tick) begin
        cnt_n = cnt + 8'd1;
        state_n = (cnt_n == CDF) ? IDLE : COOLDOWN;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_enemy_bullet_ctl.sv
// tb_enemy_bullet_ctl: directed, table and random checks against a reference model
module tb_enemy_bullet_ctl;
  logic pclk = 0, rst = 1, on = 0, frame_tick = 0, hit = 0;
  logic [11:0] enemy_xpos = 0, enemy_ypos = 0;
  logic [11:0] bullet_xpos, bullet_ypos;
  logic bullet_active, fired;
  int checks = 0, errors = 0;
  logic cmp_en = 0;
  logic m_active = 0, m_fired = 0;
  logic [11:0] m_x = 0, m_y = 0;
  int m_cool = -1;
  logic fired_seen;

  typedef struct {
    logic o, t, h;
    logic [11:0] ex, ey;
    logic a;
    logic [11:0] x, y;
    logic f;
  } vec_t;
  vec_t vt [7];

  enemy_bullet_ctl dut (
    .pclk(pclk), .rst(rst), .on(on), .frame_tick(frame_tick),
    .enemy_xpos(enemy_xpos), .enemy_ypos(enemy_ypos), .hit(hit),
    .bullet_xpos(bullet_xpos), .bullet_ypos(bullet_ypos),
    .bullet_active(bullet_active), .fired(fired)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    m_fired = 0;
    if (rst) begin
      m_active = 0; m_x = 0; m_y = 0; m_cool = -1;
    end else if (m_active) begin
      if (hit) begin
        m_active = 0; m_cool = 0;
      end else if (frame_tick) begin
        if (int'(m_y) + 4 >= 600) begin
          m_active = 0; m_cool = 0;
        end else m_y = m_y + 12'd4;
      end
    end else if (m_cool >= 0) begin
      if (m_cool == 8) m_cool = -1;
      else if (frame_tick) begin
        m_cool++;
        if (m_cool == 8) m_cool = -1;
      end
    end else if (on) begin
      m_x = enemy_xpos + 12'd16;
      m_y = enemy_ypos + 12'd32;
      m_active = 1; m_fired = 1;
    end
  end

  task automatic chk(input string n, input logic [11:0] a, input logic [11:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge pclk) if (cmp_en) begin
    chk("model_active", 12'(bullet_active), 12'(m_active));
    chk("model_fired", 12'(fired), 12'(m_fired));
    chk("model_x", bullet_xpos, m_x);
    chk("model_y", bullet_ypos, m_y);
  end

  task automatic cyc(input logic o, input logic t, input logic h);
    on = o; frame_tick = t; hit = h;
    @(posedge pclk); #1;
    on = 0; frame_tick = 0; hit = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 0;
  endtask

  task automatic chk_all(input string n, input logic a, input logic [11:0] x, input logic [11:0] y, input logic f);
    chk({n, "_active"}, 12'(bullet_active), 12'(a));
    chk({n, "_x"}, bullet_xpos, x);
    chk({n, "_y"}, bullet_ypos, y);
    chk({n, "_fired"}, 12'(fired), 12'(f));
  endtask

  initial begin
    vt[0] = '{1, 0, 0, 10, 20, 1, 26, 52, 1};
    vt[1] = '{0, 0, 0, 10, 20, 1, 26, 52, 0};
    vt[2] = '{1, 1, 0, 500, 500, 1, 26, 56, 0};
    vt[3] = '{0, 0, 0, 0, 0, 1, 26, 56, 0};
    vt[4] = '{0, 1, 1, 0, 0, 0, 26, 56, 0};
    vt[5] = '{0, 0, 1, 0, 0, 0, 26, 56, 0};
    vt[6] = '{1, 0, 0, 0, 0, 0, 26, 56, 0};
    do_reset();
    cmp_en = 1;
    chk_all("reset", 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      enemy_xpos = vt[i].ex; enemy_ypos = vt[i].ey;
      cyc(vt[i].o, vt[i].t, vt[i].h);
      chk_all($sformatf("vec%0d", i), vt[i].a, vt[i].x, vt[i].y, vt[i].f);
    end
    do_reset();
    enemy_xpos = 100; enemy_ypos = 50;
    cyc(1, 0, 0);
    chk_all("spawn", 1, 116, 82, 1);
    cyc(0, 0, 0);
    chk("fired_one_cycle", 12'(fired), 0);
    fired_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0); cyc(0, 0, 0);
      fired_seen |= fired;
    end
    chk("y_after_10", bullet_ypos, 122);
    for (int i = 10; i < 129; i++) begin
      cyc(0, 1, 0);
      fired_seen |= fired;
    end
    chk_all("tick129", 1, 116, 598, 0);
    cyc(0, 1, 0);
    fired_seen |= fired;
    chk_all("tick130", 0, 116, 598, 0);
    chk("fired_during_flight", 12'(fired_seen), 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      chk($sformatf("cool_on%0d_fired", i), 12'(fired), 0);
      chk($sformatf("cool_on%0d_active", i), 12'(bullet_active), 0);
    end
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk_all("after_cool", 1, 116, 82, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    chk("pre_hit_y", bullet_ypos, 98);
    cyc(0, 1, 1);
    chk_all("hit_tick", 0, 116, 98, 0);
    cyc(0, 1, 0);
    do_reset();
    chk_all("rst_cool", 0, 0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk_all("pre_rst_fly", 1, 116, 90, 0);
    rst = 1;
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    rst = 0;
    chk_all("rst_fly", 0, 0, 0, 0);
    cyc(1, 0, 0);
    chk_all("post_rst_spawn", 1, 116, 82, 1);
    do_reset();
    enemy_xpos = 200; enemy_ypos = 300;
    cyc(1, 1, 0);
    chk_all("on_with_tick", 1, 216, 332, 1);
    do_reset();
    enemy_ypos = 570;
    cyc(1, 0, 0);
    chk_all("low_spawn", 1, 216, 602, 1);
    cyc(0, 1, 0);
    chk_all("low_retire", 0, 216, 602, 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      enemy_xpos = 12'($urandom_range(0, 4095));
      enemy_ypos = 12'($urandom_range(0, 700));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      rst = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_bullet_ctl.md
ENEMY_BULLET_CTL -- requirements
Module: enemy_bullet_ctl

Interface
REQ-001 The block SHALL have parameter SPEED, default 4, meaning pixels of downward bullet travel per frame_tick.
REQ-002 The block SHALL have parameter Y_MAX, default 600, meaning the screen-bottom limit; reaching or passing it retires the bullet.
REQ-003 The block SHALL have parameter X_OFFSET, default 16, meaning the horizontal spawn offset from the enemy origin.
REQ-004 The block SHALL have parameter Y_OFFSET, default 32, meaning the vertical spawn offset from the enemy origin.
REQ-005 The block SHALL have parameter COOLDOWN_FRAMES, default 8, meaning frame_ticks to wait after retirement before a new shot is accepted.
REQ-006 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port on, input, 1 bit: shoot request pulse from random_shoot_gen.
REQ-009 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-010 The block SHALL have port enemy_xpos, input, 12 bits: shooting enemy x origin.
REQ-011 The block SHALL have port enemy_ypos, input, 12 bits: shooting enemy y origin.
REQ-012 The block SHALL have port hit, input, 1 bit: bullet collided with the player.
REQ-013 The block SHALL have port bullet_xpos, output, 12 bits: bullet x.
REQ-014 The block SHALL have port bullet_ypos, output, 12 bits: bullet y.
REQ-015 The block SHALL have port bullet_active, output, 1 bit: bullet is drawn and collidable.
REQ-016 The block SHALL have port fired, output, 1 bit: one-cycle pulse on accepted shot, used for sound/score.

Function
REQ-017 The block SHALL implement FSM states IDLE, FLY and COOLDOWN, and all outputs SHALL be registered.
REQ-018 In IDLE with on=1, the block SHALL do all of the following on the next edge: latch x=enemy_xpos+X_OFFSET and y=enemy_ypos+Y_OFFSET, enter FLY, set bullet_active=1, and pulse fired for 1 cycle (latency 1 cycle).
REQ-019 If on=1 coincides with frame_tick in IDLE, the block SHALL spawn the bullet without applying movement.
REQ-020 In FLY on frame_tick, the block SHALL compute y+SPEED in 13 bits; if the result is >= Y_MAX it SHALL enter COOLDOWN, clear bullet_active and hold bullet_ypos; otherwise it SHALL set y to the result.
REQ-021 In FLY with hit=1, the block SHALL enter COOLDOWN and clear bullet_active on the next edge, and hit SHALL take priority over a simultaneous frame_tick, so y is not advanced.
REQ-022 In FLY and COOLDOWN, the block SHALL ignore on, and SHALL NOT assert fired.
REQ-023 In FLY, bullet_xpos SHALL stay constant, and enemy_xpos/enemy_ypos changes SHALL be ignored.
REQ-024 On entering COOLDOWN, the block SHALL load its counter with 0, and SHALL increment it on each frame_tick.
REQ-025 The block SHALL leave COOLDOWN for IDLE once the count equals COOLDOWN_FRAMES; with COOLDOWN_FRAMES=0 it SHALL return to IDLE the cycle after entry.
REQ-026 In IDLE and COOLDOWN, the block SHALL ignore hit.
REQ-027 A spawn y of 13-bit sum >= Y_MAX SHALL enter FLY and retire on the first frame_tick.
REQ-028 The cooldown counter SHALL be 8 bits wide, so COOLDOWN_FRAMES <= 255.

Reset
REQ-029 While rst=1 on a pclk edge, the block SHALL enter IDLE with bullet_xpos=0, bullet_ypos=0, bullet_active=0, fired=0 and cooldown counter=0.
REQ-030 Reset SHALL override every input, including reset asserted mid-FLY or mid-COOLDOWN, and a bullet SHALL NOT survive reset.

Structure
REQ-031 The shared game package SHALL hold the 12-bit coordinate width and the Y_MAX screen-height constant.
REQ-032 The FSM state encoding SHALL be local to the block.
REQ-033 The block SHALL be a single module with no sub-modules; frame_tick is generated externally.

Verification
REQ-034 The bench SHALL apply enemy (100,50) with an on pulse and require, the next cycle: active=1, x=116, y=82, fired high for exactly 1 cycle; after 10 frame_ticks, y=122.
REQ-035 The bench SHALL continue ticking from y=82 and require active to drop after the 130th tick with y held at 598; fired SHALL stay 0 throughout.
REQ-036 The bench SHALL assert hit together with the 5th frame_tick and require active=0 with y=98, not 102.
REQ-037 The bench SHALL pulse on at cooldown ticks 1..7 and require none accepted, then require on after the 8th tick to spawn with fired=1.
REQ-038 The bench SHALL assert rst for 2 cycles mid-FLY and require all outputs 0 and IDLE, then require the next on to spawn normally.
REQ-039 The bench SHALL assert on and frame_tick in the same IDLE cycle and require y=enemy_ypos+32 with no SPEED added.
